// File: rtl/ts_sched_pkg.sv
// Shared types and helpers for the timestamp event scheduler.
// Timestamps compare modulo 2^TS_WIDTH; a target counts as reached for half the range.
package ts_sched_pkg;

    localparam int TS_WIDTH_DEF = 16;

    function automatic int slot_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // True when ts is at or up to 2^(w-1)-1 past tgt, i.e. MSB of (ts - tgt) mod 2^w is clear.
    function automatic logic ts_reached(input logic [31:0] ts, input logic [31:0] tgt,
                                        input int w);
        logic [31:0] diff;
        diff = ts - tgt;
        return (diff & (32'd1 << (w - 1))) == 32'd0;
    endfunction

endpackage

// File: rtl/ts_event_scheduler_if.sv
// Timestamp, configuration and event-stream bundle for ts_event_scheduler.
interface ts_event_scheduler_if
    import ts_sched_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int TS_WIDTH  = TS_WIDTH_DEF
);
    localparam int SW = slot_w(NUM_SLOTS);

    logic [TS_WIDTH-1:0]  timestamp;
    logic                 cfg_valid;
    logic [SW-1:0]        cfg_slot;
    logic                 cfg_enable;
    logic [TS_WIDTH-1:0]  cfg_time;
    logic [TS_WIDTH-1:0]  cfg_period;
    logic                 ev_valid;
    logic                 ev_ready;
    logic [SW-1:0]        ev_slot;
    logic [TS_WIDTH-1:0]  ev_time;
    logic [NUM_SLOTS-1:0] armed;
    logic [NUM_SLOTS-1:0] overrun;

    modport master (
        output timestamp, cfg_valid, cfg_slot, cfg_enable, cfg_time, cfg_period, ev_ready,
        input  ev_valid, ev_slot, ev_time, armed, overrun
    );

    modport slave (
        input  timestamp, cfg_valid, cfg_slot, cfg_enable, cfg_time, cfg_period, ev_ready,
        output ev_valid, ev_slot, ev_time, armed, overrun
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or after ptr_i, wrapping.
module rr_arbiter
    import ts_sched_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = slot_w(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_oh_o,
    output logic [W-1:0] gnt_idx_o,
    output logic         gnt_vld_o
);

    always_comb begin
        logic [W:0]   s;
        logic [W-1:0] idx;
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        s         = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            s = {1'b0, ptr_i} + (W+1)'(k);
            if (s >= (W+1)'(N)) s = s - (W+1)'(N);
            idx = s[W-1:0];
            if (!gnt_vld_o && req_i[idx]) begin
                gnt_vld_o      = 1'b1;
                gnt_oh_o[idx]  = 1'b1;
                gnt_idx_o      = idx;
            end
        end
    end

endmodule

// File: rtl/ts_event_scheduler.sv
// NUM_SLOTS timestamp-triggered slots (one-shot or periodic) feeding one valid/ready event
// stream through a round-robin arbiter; each slot buffers one pending firing plus the presented one.
module ts_event_scheduler
    import ts_sched_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int TS_WIDTH  = TS_WIDTH_DEF
) (
    input logic clk,
    input logic rst,
    ts_event_scheduler_if.slave bus
);
    localparam int SW = slot_w(NUM_SLOTS);

    logic [NUM_SLOTS-1:0]               armed_v, pend_v, ovr_v, gnt_oh;
    logic [NUM_SLOTS-1:0][TS_WIDTH-1:0] ptime_v;
    logic [SW-1:0]                      gnt_idx, rr_q, rr_d;
    logic                               gnt_vld, load;
    logic                               ev_valid_q, ev_valid_d;
    logic [SW-1:0]                      ev_slot_q, ev_slot_d;
    logic [TS_WIDTH-1:0]                ev_time_q, ev_time_d;

    assign load = !ev_valid_q || bus.ev_ready;

    rr_arbiter #(.N(NUM_SLOTS)) u_arb (
        .req_i     (pend_v),
        .ptr_i     (rr_q),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        logic                armed_q, armed_d, pend_q, pend_d, ovr_q, ovr_d;
        logic [TS_WIDTH-1:0] tgt_q, tgt_d, per_q, per_d, ptime_q, ptime_d;
        logic                cfg_hit, reached, due;

        assign cfg_hit = bus.cfg_valid && (bus.cfg_slot == SW'(i));
        assign reached = ts_reached(32'(bus.timestamp), 32'(tgt_q), TS_WIDTH);
        assign due     = armed_q && !pend_q && reached;

        // A config write to this slot overrides any due/grant activity in the same cycle.
        always_comb begin
            armed_d = armed_q;
            pend_d  = pend_q;
            ovr_d   = ovr_q;
            tgt_d   = tgt_q;
            per_d   = per_q;
            ptime_d = ptime_q;
            if (cfg_hit) begin
                armed_d = bus.cfg_enable;
                pend_d  = 1'b0;
                if (bus.cfg_enable) begin
                    tgt_d = bus.cfg_time;
                    per_d = bus.cfg_period;
                    ovr_d = 1'b0;
                end
            end else begin
                if (due) begin
                    pend_d  = 1'b1;
                    ptime_d = tgt_q;
                    if (per_q != '0) tgt_d = tgt_q + per_q;
                    else             armed_d = 1'b0;
                end else if (load && gnt_oh[i]) begin
                    pend_d = 1'b0;
                end
                if (armed_q && pend_q && reached) ovr_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                armed_q <= 1'b0;
                pend_q  <= 1'b0;
                ovr_q   <= 1'b0;
                tgt_q   <= '0;
                per_q   <= '0;
                ptime_q <= '0;
            end else begin
                armed_q <= armed_d;
                pend_q  <= pend_d;
                ovr_q   <= ovr_d;
                tgt_q   <= tgt_d;
                per_q   <= per_d;
                ptime_q <= ptime_d;
            end
        end

        assign armed_v[i] = armed_q;
        assign pend_v[i]  = pend_q;
        assign ovr_v[i]   = ovr_q;
        assign ptime_v[i] = ptime_q;
    end

    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_slot_d  = ev_slot_q;
        ev_time_d  = ev_time_q;
        rr_d       = rr_q;
        if (load) begin
            ev_valid_d = gnt_vld;
            if (gnt_vld) begin
                ev_slot_d = gnt_idx;
                ev_time_d = ptime_v[gnt_idx];
                rr_d      = (gnt_idx == SW'(NUM_SLOTS - 1)) ? '0 : gnt_idx + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_valid_q <= 1'b0;
            ev_slot_q  <= '0;
            ev_time_q  <= '0;
            rr_q       <= '0;
        end else begin
            ev_valid_q <= ev_valid_d;
            ev_slot_q  <= ev_slot_d;
            ev_time_q  <= ev_time_d;
            rr_q       <= rr_d;
        end
    end

    assign bus.ev_valid = ev_valid_q;
    assign bus.ev_slot  = ev_slot_q;
    assign bus.ev_time  = ev_time_q;
    assign bus.armed    = armed_v;
    assign bus.overrun  = ovr_v;

endmodule

// File: tb/tb_ts_event_scheduler.sv
// Directed bench for ts_event_scheduler; one timestamp step per clock, handshakes logged at negedge.
module tb_ts_event_scheduler;
    import ts_sched_pkg::*;

    localparam int NS = 4;
    localparam int TW = 16;
    localparam int SW = slot_w(NS);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ts_event_scheduler_if #(.NUM_SLOTS(NS), .TS_WIDTH(TW)) bus ();

    ts_event_scheduler #(.NUM_SLOTS(NS), .TS_WIDTH(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int slot;
        int tm;
        int ts;
    } ev_t;

    ev_t evq[$];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (!rst && bus.ev_valid && bus.ev_ready)
            evq.push_back('{int'(bus.ev_slot), int'(bus.ev_time), int'(bus.timestamp)});

    task automatic tick();
        @(posedge clk);
        #1;
        bus.timestamp = bus.timestamp + 16'd1;
    endtask

    task automatic run_to(input int t);
        for (int n = 0; n < 1000 && bus.timestamp != TW'(t); n++) tick();
        chk("run_to", 32'(bus.timestamp), 32'(t));
    endtask

    task automatic cfg(input int s, input bit en, input int t, input int p);
        bus.cfg_valid  = 1'b1;
        bus.cfg_slot   = SW'(s);
        bus.cfg_enable = en;
        bus.cfg_time   = TW'(t);
        bus.cfg_period = TW'(p);
        tick();
        bus.cfg_valid  = 1'b0;
    endtask

    task automatic do_reset(input int t);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.timestamp = TW'(t);
        evq.delete();
    endtask

    task automatic chk_ev(input int i, input int s, input int tm, input int ts);
        if (i < evq.size()) begin
            chk($sformatf("ev%0d_slot", i), evq[i].slot, s);
            chk($sformatf("ev%0d_time", i), evq[i].tm, tm);
            chk($sformatf("ev%0d_ts", i), evq[i].ts, ts);
        end else begin
            chk($sformatf("ev%0d_count", i), evq.size(), i + 1);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_ev_valid"}, 32'(bus.ev_valid), 0);
        chk({pfx, "_ev_slot"},  32'(bus.ev_slot), 0);
        chk({pfx, "_ev_time"},  32'(bus.ev_time), 0);
        chk({pfx, "_armed"},    32'(bus.armed), 0);
        chk({pfx, "_overrun"},  32'(bus.overrun), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus.timestamp  = '0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_slot   = '0;
        bus.cfg_enable = 1'b0;
        bus.cfg_time   = '0;
        bus.cfg_period = '0;
        bus.ev_ready   = 1'b1;

        // one-shot on slot 2
        do_reset(90);
        chk_reset_outputs("rst");
        cfg(2, 1'b1, 100, 0);
        chk("os_armed", 32'(bus.armed), 32'h4);
        run_to(110);
        chk("os_count", evq.size(), 1);
        chk_ev(0, 2, 100, 102);
        chk("os_disarmed", 32'(bus.armed), 0);

        // periodic across the timestamp wrap
        do_reset(65525);
        cfg(0, 1'b1, 65530, 10);
        run_to(20);
        chk("wrap_count", evq.size(), 3);
        chk_ev(0, 0, 65530, 65532);
        chk_ev(1, 0, 4, 6);
        chk_ev(2, 0, 14, 16);

        // target already in the past: catch-up firings, none skipped
        do_reset(500);
        cfg(1, 1'b1, 490, 5);
        run_to(521);
        chk("past_count", evq.size(), 6);
        chk_ev(0, 1, 490, 503);
        chk_ev(1, 1, 495, 505);
        chk_ev(2, 1, 500, 507);
        chk_ev(3, 1, 505, 509);
        chk_ev(4, 1, 510, 512);
        chk_ev(5, 1, 515, 517);

        // contention, then a round that starts from the saved pointer
        do_reset(40);
        bus.ev_ready = 1'b0;
        for (int s = 0; s < NS; s++) cfg(s, 1'b1, 50, 0);
        run_to(52);
        chk("ct_valid", 32'(bus.ev_valid), 1);
        chk("ct_slot", 32'(bus.ev_slot), 0);
        chk("ct_time", 32'(bus.ev_time), 50);
        run_to(54);
        chk("ct_hold_slot", 32'(bus.ev_slot), 0);
        bus.ev_ready = 1'b1;
        run_to(58);
        cfg(2, 1'b1, 70, 0);
        cfg(0, 1'b1, 80, 0);
        cfg(3, 1'b1, 80, 0);
        run_to(90);
        chk("ct_count", evq.size(), 7);
        chk_ev(0, 0, 50, 54);
        chk_ev(1, 1, 50, 55);
        chk_ev(2, 2, 50, 56);
        chk_ev(3, 3, 50, 57);
        chk_ev(4, 2, 70, 72);
        chk_ev(5, 3, 80, 82);
        chk_ev(6, 0, 80, 83);

        // stall with a period-1 slot: output holds, overrun sticks until re-armed
        do_reset(200);
        bus.ev_ready = 1'b0;
        cfg(3, 1'b1, 205, 1);
        chk("ov_clear", 32'(bus.overrun), 0);
        run_to(207);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_valid", k), 32'(bus.ev_valid), 1);
            chk($sformatf("stall%0d_slot", k), 32'(bus.ev_slot), 3);
            chk($sformatf("stall%0d_time", k), 32'(bus.ev_time), 205);
            chk($sformatf("stall%0d_ovr", k), 32'(bus.overrun), 32'h8);
            tick();
        end
        bus.ev_ready = 1'b1;
        run_to(216);
        chk("ov_count", evq.size(), 3);
        chk_ev(0, 3, 205, 212);
        chk_ev(1, 3, 206, 213);
        chk_ev(2, 3, 207, 215);
        chk("ov_sticky", 32'(bus.overrun), 32'h8);
        cfg(3, 1'b1, 1000, 0);
        chk("ov_rearm_clr", 32'(bus.overrun), 0);
        chk("ov_rearm_arm", 32'(bus.armed), 32'h8);

        // config collides with the due cycle: new target wins, old one never fires
        do_reset(300);
        cfg(1, 1'b1, 305, 0);
        run_to(305);
        cfg(1, 1'b1, 320, 0);
        run_to(325);
        chk("col_count", evq.size(), 1);
        chk_ev(0, 1, 320, 322);

        // reset mid-stream drops presented and pending events
        bus.ev_ready = 1'b0;
        run_to(330);
        cfg(0, 1'b1, 330, 1);
        run_to(334);
        chk("mid_valid", 32'(bus.ev_valid), 1);
        chk("mid_time", 32'(bus.ev_time), 330);
        rst = 1'b1;
        tick();
        chk_reset_outputs("mid_rst");
        rst = 1'b0;
        bus.ev_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("post_rst_valid", 32'(bus.ev_valid), 0);
        chk("post_rst_armed", 32'(bus.armed), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
